// File: rtl/exec_stage.sv
// exec_stage: single-cycle ALU ops plus an iterative shift-add multiplier feeding reg_file write strobes
module exec_stage #(
  parameter int reg_width = 8,
  parameter int num_regs = 12,
  localparam int AW = $clog2(num_regs)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [reg_width-1:0] rs_val,
  input  logic [reg_width-1:0] rt_val,
  input  logic [reg_width-1:0] car_val,
  input  logic [AW-1:0]        rd_addr_in,
  output logic [AW-1:0]        rd_addr,
  output logic [reg_width-1:0] rd_in,
  output logic                 reg_write,
  output logic [reg_width-1:0] car_in,
  output logic                 car_write
);
  localparam int W = reg_width;
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] mc, acc, acc_nx, shl_w, shr_w;
  logic [W-1:0] mp, res;
  logic [W:0] sum, dif;
  logic c, res_car, wr_rd, wr_car, unused;
  assign in_ready = state == IDLE;
  assign unused = ^car_val[W-1:1];
  assign acc_nx = acc + (mp[0] ? mc : '0);
  always_comb begin
    c = car_write ? car_in[0] : car_val[0];
    sum = {1'b0, rs_val} + {1'b0, rt_val} + {{W{1'b0}}, op == 4'd1 && c};
    dif = {1'b0, rs_val} - {1'b0, rt_val};
    shl_w = {{W{1'b0}}, rs_val} << rt_val[2:0];
    shr_w = {rs_val, {W{1'b0}}} >> rt_val[2:0];
    res = '0;
    res_car = 1'b0;
    wr_rd = 1'b1;
    wr_car = 1'b1;
    case (op)
      4'd0, 4'd1: {res_car, res} = sum;
      4'd2: {res_car, res} = dif;
      4'd3: begin res = rs_val & rt_val; wr_car = 1'b0; end
      4'd4: begin res = rs_val | rt_val; wr_car = 1'b0; end
      4'd5: begin res = rs_val ^ rt_val; wr_car = 1'b0; end
      4'd6: begin res = shl_w[W-1:0]; res_car = shl_w[W]; end
      4'd7: begin res = shr_w[2*W-1:W]; res_car = shr_w[W-1]; end
      4'd9: begin res = rs_val; wr_car = 1'b0; end
      default: begin wr_rd = 1'b0; wr_car = 1'b0; end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mc <= '0;
      mp <= '0;
      acc <= '0;
      rd_addr <= '0;
      rd_in <= '0;
      car_in <= '0;
      reg_write <= 1'b0;
      car_write <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      car_write <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          rd_addr <= rd_addr_in;
          if (op == 4'd8) begin
            state <= MUL;
            cnt <= '0;
            mc <= {{W{1'b0}}, rs_val};
            mp <= rt_val;
            acc <= '0;
          end else begin
            if (wr_rd) rd_in <= res;
            if (wr_car) car_in <= {{(W-1){1'b0}}, res_car};
            reg_write <= wr_rd && rd_addr_in != '0;
            car_write <= wr_car;
          end
        end
      end else begin
        acc <= acc_nx;
        mc <= mc << 1;
        mp <= mp >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          state <= IDLE;
          rd_in <= acc_nx[W-1:0];
          car_in <= acc_nx[2*W-1:W];
          reg_write <= rd_addr != '0;
          car_write <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and random ops against an arithmetic reference model
module tb_exec_stage;
  localparam int W = 8;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] op = '0;
  logic [W-1:0] rs_val = '0, rt_val = '0, car_val = '0, rd_in, car_in;
  logic [AW-1:0] rd_addr_in = '0, rd_addr;
  logic reg_write, car_write;
  int tests = 0;
  int fails = 0;
  int pcw = 0;
  int pcar = 0;
  always #5 clk = ~clk;
  exec_stage #(.reg_width(W), .num_regs(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .car_val(car_val), .rd_addr_in(rd_addr_in),
    .rd_addr(rd_addr), .rd_in(rd_in), .reg_write(reg_write), .car_in(car_in), .car_write(car_write)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input int o, input int rs, input int rt, input int cv,
                       output int r, output int k, output int hr, output int hk);
    int c, n, s;
    c = pcw != 0 ? pcar % 2 : cv % 2;
    n = rt % 8;
    hr = 1;
    hk = 1;
    r = 0;
    k = 0;
    case (o)
      0: begin s = rs + rt; r = s % (1 << W); k = s / (1 << W); end
      1: begin s = rs + rt + c; r = s % (1 << W); k = s / (1 << W); end
      2: begin r = (rs - rt + (1 << W)) % (1 << W); k = rs < rt ? 1 : 0; end
      3: begin r = rs & rt; hk = 0; end
      4: begin r = rs | rt; hk = 0; end
      5: begin r = rs ^ rt; hk = 0; end
      6: begin r = (rs << n) % (1 << W); k = n == 0 ? 0 : (rs >> (W - n)) % 2; end
      7: begin r = rs >> n; k = n == 0 ? 0 : (rs >> (n - 1)) % 2; end
      8: begin s = rs * rt; r = s % (1 << W); k = s / (1 << W); end
      9: begin r = rs; hk = 0; end
      default: begin hr = 0; hk = 0; end
    endcase
  endtask
  task automatic drive(input int o, input int rs, input int rt, input int cv, input int rd, input bit v);
    logic [31:0] t;
    in_valid = v;
    t = o; op = t[3:0];
    t = rs; rs_val = t[W-1:0];
    t = rt; rt_val = t[W-1:0];
    t = cv; car_val = t[W-1:0];
    t = rd; rd_addr_in = t[AW-1:0];
  endtask
  task automatic step(input int o, input int rs, input int rt, input int cv, input int rd, input bit v);
    int r, k, hr, hk, erw, ecw;
    drive(o, rs, rt, cv, rd, v);
    model(o, rs, rt, cv, r, k, hr, hk);
    @(posedge clk); #1;
    erw = (v && hr != 0 && rd != 0) ? 1 : 0;
    ecw = (v && hk != 0) ? 1 : 0;
    chk($sformatf("op%0d reg_write", o), reg_write, erw);
    chk($sformatf("op%0d car_write", o), car_write, ecw);
    chk($sformatf("op%0d in_ready", o), in_ready, 1);
    if (v && hr != 0) chk($sformatf("op%0d rd_in", o), rd_in, r);
    if (ecw != 0) chk($sformatf("op%0d car_in", o), car_in, k);
    if (erw != 0 || ecw != 0) chk($sformatf("op%0d rd_addr", o), rd_addr, rd);
    pcw = ecw;
    pcar = k;
  endtask
  task automatic mul(input int rs, input int rt, input int cv, input int rd);
    int r, k, hr, hk;
    drive(8, rs, rt, cv, rd, 1'b1);
    model(8, rs, rt, cv, r, k, hr, hk);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mul busy%0d in_ready", i), in_ready, 0);
      chk($sformatf("mul busy%0d strobes", i), {reg_write, car_write}, 0);
      drive(0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 5, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mul in_ready", in_ready, 1);
    chk("mul reg_write", reg_write, rd != 0 ? 1 : 0);
    chk("mul car_write", car_write, 1);
    chk("mul rd_in", rd_in, r);
    chk("mul car_in", car_in, k);
    chk("mul rd_addr", rd_addr, rd);
    @(posedge clk); #1;
    chk("mul single strobe", {reg_write, car_write}, 0);
    pcw = 0;
  endtask
  initial begin
    #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset outputs", {rd_addr, rd_in, car_in, reg_write, car_write}, 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 'hF0, 'h20, 0, 3, 1'b1);
    step(2, 'h05, 'h07, 0, 4, 1'b1);
    step(6, 'h81, 1, 0, 5, 1'b1);
    step(7, 'h81, 0, 0, 5, 1'b1);
    mul('hC8, 'h05, 0, 6);
    step(0, 'hFF, 'h01, 0, 2, 1'b1);
    step(1, 'h00, 'h00, 0, 7, 1'b1);
    chk("adc forward rd_in", rd_in, 1);
    step(0, 1, 2, 0, 0, 1'b1);
    step(15, 3, 4, 0, 3, 1'b1);
    step(0, 3, 4, 0, 3, 1'b0);
    drive(8, 'h37, 'h9A, 0, 9, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort outputs", {rd_addr, rd_in, car_in, reg_write, car_write}, 0);
    chk("abort in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    pcw = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("abort no strobe", {reg_write, car_write}, 0);
    end
    chk("abort in_ready after", in_ready, 1);
    for (int i = 0; i < 80; i++) begin
      int o;
      bit v;
      o = $urandom_range(0, 15);
      v = $urandom_range(0, 3) != 0;
      if (o == 8 && v) mul($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 11));
      else step(o, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 11), v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
